// File: rtl/memory_arbiter_if.sv
// Memory valid/ready bundle: request channel (m_*) and response channel (s_*).
// master drives requests and accepts responses; slave is the opposite side.
interface Memory #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data;
  logic          m_write;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  modport master (
    output m_address, m_data, m_write, m_valid, s_ready,
    input  m_ready, s_data, s_valid
  );

  modport slave (
    input  m_address, m_data, m_write, m_valid, s_ready,
    output m_ready, s_data, s_valid
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter with a tag FIFO routing responses back in order.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin; default is port-0 priority.
module memory_arbiter #(
  parameter int DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  Memory.slave  req0,
  Memory.slave  req1,
  Memory.master mem
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      count;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [DEPTH-1:0] tags;
  logic             locked;
  logic             lock_g;
  logic             g;
  logic             h;
  logic             full;
  logic             empty;
  logic             mv;
  logic             sr;
  logic             push;
  logic             pop;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic             last;
`endif

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign h     = tags[rptr];

  always_comb begin
    g = 1'b0;
    if (locked) begin
      g = lock_g;
    end else if (req0.m_valid && req1.m_valid) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      g = ~last;
`else
      g = 1'b0;
`endif
    end else if (req1.m_valid) begin
      g = 1'b1;
    end
  end

  assign mem.m_address = g ? req1.m_address : req0.m_address;
  assign mem.m_data    = g ? req1.m_data    : req0.m_data;
  assign mem.m_write   = g ? req1.m_write   : req0.m_write;

  assign mv            = !rst && !full && (g ? req1.m_valid : req0.m_valid);
  assign mem.m_valid   = mv;
  assign req0.m_ready  = !rst && !full && !g && mem.m_ready;
  assign req1.m_ready  = !rst && !full &&  g && mem.m_ready;
  assign push          = mv && mem.m_ready;

  // Responses follow the port id at the FIFO head; nothing passes when empty.
  assign sr            = !rst && !empty && (h ? req1.s_ready : req0.s_ready);
  assign mem.s_ready   = sr;
  assign req0.s_valid  = !rst && !empty && !h && mem.s_valid;
  assign req1.s_valid  = !rst && !empty &&  h && mem.s_valid;
  assign req0.s_data   = mem.s_data;
  assign req1.s_data   = mem.s_data;
  assign pop           = mem.s_valid && sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
      tags   <= '0;
      locked <= 1'b0;
      lock_g <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last   <= 1'b1;
`endif
    end else begin
      if (push) begin
        tags[wptr] <= g;
        wptr       <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      // Hold the grant on a stalled request so its address stays stable.
      if (push) begin
        locked <= 1'b0;
      end else if (mv && !mem.m_ready) begin
        locked <= 1'b1;
        lock_g <= g;
      end
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      if (push) begin
        last <= g;
      end
`endif
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against a queue-based model.
// Honors MEMORY_ARBITER_ROUND_ROBIN_EN the same way as the design.
module tb_memory_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  Memory r0 ();
  Memory r1 ();
  Memory m ();

  memory_arbiter #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (r0),
    .req1 (r1),
    .mem  (m)
  );

  logic        v0 = 0, v1 = 0, w0 = 0, w1 = 0;
  logic [31:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0;
  logic        sr0 = 0, sr1 = 0, mr = 0, sv = 0;
  logic [31:0] sd = 0;

  assign r0.m_valid   = v0;
  assign r0.m_address = a0;
  assign r0.m_data    = d0;
  assign r0.m_write   = w0;
  assign r0.s_ready   = sr0;
  assign r1.m_valid   = v1;
  assign r1.m_address = a1;
  assign r1.m_data    = d1;
  assign r1.m_write   = w1;
  assign r1.s_ready   = sr1;
  assign m.m_ready    = mr;
  assign m.s_valid    = sv;
  assign m.s_data     = sd;

  int errors = 0;
  int checks = 0;

  // Reference state: outstanding port ids in order, plus arbitration memory.
  int q[$];
  bit lk = 0, lkg = 0, last = 1;
  bit acc0 = 0, acc1 = 0;
  bit e_g, e_mv, e_r0, e_r1, e_sv0, e_sv1, e_sr;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic calc();
    bit full, empty, h;
    full  = (q.size() >= DEPTH);
    empty = (q.size() == 0);
    h     = empty ? 1'b0 : q[0][0];
    if (lk) e_g = lkg;
    else if (v0 && v1) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      e_g = !last;
`else
      e_g = 1'b0;
`endif
    end else e_g = v1;
    e_mv  = !rst && !full && (e_g ? v1 : v0);
    e_r0  = !rst && !full && !e_g && mr;
    e_r1  = !rst && !full && e_g && mr;
    e_sr  = !rst && !empty && (h ? sr1 : sr0);
    e_sv0 = !rst && !empty && !h && sv;
    e_sv1 = !rst && !empty && h && sv;
  endtask

  task automatic check_all();
    calc();
    chk("m_valid", m.m_valid, e_mv);
    chk("req0_m_ready", r0.m_ready, e_r0);
    chk("req1_m_ready", r1.m_ready, e_r1);
    if (e_mv) begin
      chk("m_address", m.m_address, e_g ? a1 : a0);
      chk("m_data", m.m_data, e_g ? d1 : d0);
      chk("m_write", m.m_write, e_g ? w1 : w0);
    end
    chk("s_ready", m.s_ready, e_sr);
    chk("req0_s_valid", r0.s_valid, e_sv0);
    chk("req1_s_valid", r1.s_valid, e_sv1);
    chk("req0_s_data", r0.s_data, sd);
    chk("req1_s_data", r1.s_data, sd);
  endtask

  task automatic update();
    bit push, pop;
    calc();
    acc0 = 0;
    acc1 = 0;
    if (rst) begin
      q.delete();
      lk   = 0;
      last = 1;
      return;
    end
    push = e_mv && mr;
    pop  = sv && e_sr;
    acc0 = push && !e_g;
    acc1 = push && e_g;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(int'(e_g));
    if (push) lk = 0;
    else if (e_mv && !mr) begin
      lk  = 1;
      lkg = e_g;
    end
    if (push) last = e_g;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  bit [3:0] gs;

  initial begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    gs = 4'b1010;
`else
    gs = 4'b0000;
`endif
    #1;
    do_reset();
    chk("reset_count", q.size(), 0);

    // Conflict grants, then FIFO full blocking.
    v0 = 1; a0 = 32'h10; v1 = 1; a1 = 32'h20; mr = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("grant_seq", r1.m_ready, gs[i]);
      cyc();
    end
    #1 chk("full_m_valid", m.m_valid, 0);
    chk("full_req0_ready", r0.m_ready, 0);
    sv = 1; sd = 32'hA5; sr0 = 1; sr1 = 1;
    #1 chk("full_pop_m_valid", m.m_valid, 0);
    chk("full_pop_s_ready", m.s_ready, 1);
    cyc();
    sv = 0;
    #1 chk("after_pop_m_valid", m.m_valid, 1);
    cyc();
    v0 = 0; v1 = 0; mr = 0; sv = 1;
    for (int i = 0; i < 4; i++) cyc();
    sv = 0;
    cyc();

    // Single read from port 0 and its response.
    do_reset();
    v0 = 1; a0 = 32'h100; w0 = 0; mr = 1;
    #1 chk("r0_accept", r0.m_ready, 1);
    chk("r0_addr", m.m_address, 32'h100);
    cyc();
    v0 = 0; mr = 0;
    sv = 1; sd = 32'hDEADBEEF; sr0 = 1;
    #1 chk("resp_r0_valid", r0.s_valid, 1);
    chk("resp_r1_valid", r1.s_valid, 0);
    chk("resp_data", r0.s_data, 32'hDEADBEEF);
    cyc();
    sv = 0;

    // Stalled request keeps its grant.
    v1 = 1; a1 = 32'h200; mr = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        v0 = 1; a0 = 32'h300;
      end
      #1 chk("lock_addr", m.m_address, 32'h200);
      chk("lock_r0_ready", r0.m_ready, 0);
      cyc();
    end
    mr = 1;
    #1 chk("lock_r1_ready", r1.m_ready, 1);
    cyc();
    v1 = 0;
    #1 chk("next_r0_ready", r0.m_ready, 1);
    chk("next_addr", m.m_address, 32'h300);
    cyc();
    v0 = 0; mr = 0; sv = 1; sr0 = 1; sr1 = 1;
    cyc();
    cyc();
    sv = 0;

    // Response back-pressure from requester 0.
    v0 = 1; mr = 1;
    cyc();
    v0 = 0; v1 = 1;
    cyc();
    v1 = 0; mr = 0;
    sv = 1; sd = 32'h11111111; sr0 = 0; sr1 = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bp_s_ready", m.s_ready, 0);
      chk("bp_r0_valid", r0.s_valid, 1);
      cyc();
    end
    sr0 = 1;
    #1 chk("bp_release", m.s_ready, 1);
    cyc();
    sd = 32'h22222222;
    #1 chk("second_r1_valid", r1.s_valid, 1);
    chk("second_r0_valid", r0.s_valid, 0);
    cyc();
    sv = 0;

    // Reset with two outstanding, then a stray response.
    v0 = 1; mr = 1;
    cyc();
    v0 = 0; v1 = 1;
    cyc();
    v1 = 0; mr = 0;
    do_reset();
    chk("rst_count", q.size(), 0);
    sv = 1; sd = 32'h33;
    #1 chk("stray_s_ready", m.s_ready, 0);
    chk("stray_r0", r0.s_valid, 0);
    chk("stray_r1", r1.s_valid, 0);
    cyc();
    sv = 0;

    // Random traffic; requesters hold a request until accepted.
    for (int n = 0; n < 3000; n++) begin
      if (acc0 || !v0) begin
        v0 = 1'($urandom_range(0, 1));
        a0 = $urandom; d0 = $urandom; w0 = 1'($urandom_range(0, 1));
      end
      if (acc1 || !v1) begin
        v1 = 1'($urandom_range(0, 1));
        a1 = $urandom; d1 = $urandom; w1 = 1'($urandom_range(0, 1));
      end
      mr  = ($urandom % 4) != 0;
      sv  = ($urandom % 3) == 0;
      sd  = $urandom;
      sr0 = ($urandom % 4) != 0;
      sr1 = ($urandom % 4) != 0;
      rst = ($urandom % 300) == 0;
      cyc();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
